// File: rtl/memory_responder.sv
// Multi-channel memory endpoint: per-channel request FSMs share one word array
// through a round-robin arbiter, with a fixed response latency after each access.

module memory_responder_chan #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rd_valid_i,
  input  logic [ADDR_BITS-1:0] rd_addr_i,
  input  logic                 wr_valid_i,
  input  logic [ADDR_BITS-1:0] wr_addr_i,
  input  logic [DATA_BITS-1:0] wr_data_i,
  input  logic                 gnt_i,
  input  logic [DATA_BITS-1:0] mem_rdata_i,
  output logic                 req_o,
  output logic                 op_wr_o,
  output logic [ADDR_BITS-1:0] addr_o,
  output logic [DATA_BITS-1:0] wdata_o,
  output logic                 rd_ready_o,
  output logic                 wr_ready_o,
  output logic [DATA_BITS-1:0] rd_data_o
);
  localparam int CNTW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNTW-1:0] LAT_M1 = CNTW'((LATENCY > 0) ? LATENCY - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_PENDING, S_WAIT, S_RESPOND, S_DRAIN} state_e;

  state_e               state_q, state_d;
  logic                 op_wr_q, op_wr_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic [DATA_BITS-1:0] rdata_q, rdata_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        // Reads take precedence; a concurrent write is picked up on a later pass.
        if (rd_valid_i) begin
          addr_d  = rd_addr_i;
          op_wr_d = 1'b0;
          state_d = S_PENDING;
        end else if (wr_valid_i) begin
          addr_d  = wr_addr_i;
          wdata_d = wr_data_i;
          op_wr_d = 1'b1;
          state_d = S_PENDING;
        end
      end
      S_PENDING: begin
        if (gnt_i) begin
          if (!op_wr_q) rdata_d = mem_rdata_i;
          if (LATENCY == 0) begin
            state_d = S_RESPOND;
          end else begin
            cnt_d   = LAT_M1;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_RESPOND;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_RESPOND: state_d = S_DRAIN;
      S_DRAIN: begin
        // Wait for the requester to release valid so one request is served once.
        if (op_wr_q ? !wr_valid_i : !rd_valid_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_o      = (state_q == S_PENDING);
  assign op_wr_o    = op_wr_q;
  assign addr_o     = addr_q;
  assign wdata_o    = wdata_q;
  assign rd_ready_o = (state_q == S_RESPOND) && !op_wr_q;
  assign wr_ready_o = (state_q == S_RESPOND) &&  op_wr_q;
  assign rd_data_o  = rdata_q;
endmodule

module memory_responder #(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int LATENCY      = 2
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_CHANNELS-1:0]                mem_read_valid,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_read_address,
  output logic [NUM_CHANNELS-1:0]                mem_read_ready,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_read_data,
  input  logic [NUM_CHANNELS-1:0]                mem_write_valid,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_write_address,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_write_data,
  output logic [NUM_CHANNELS-1:0]                mem_write_ready,
  input  logic                                   load_en,
  input  logic [ADDR_BITS-1:0]                   load_addr,
  input  logic [DATA_BITS-1:0]                   load_data
);
  localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  logic [DATA_BITS-1:0] mem_q [2**ADDR_BITS];

  logic [NUM_CHANNELS-1:0]                req, op_wr, gnt_vec;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] addr_w;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] wdata_w;
  logic [CW-1:0]                          rr_q, rr_d, gnt_idx;
  logic                                   gnt_vld;
  logic [DATA_BITS-1:0]                   mem_rdata;

  // Round-robin search from rr_q; backdoor load and reset suppress the grant.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      idx = (int'(rr_q) + i) % NUM_CHANNELS;
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = CW'(idx);
      end
    end
    if (load_en || reset) gnt_vld = 1'b0;
  end

  always_comb begin
    gnt_vec = '0;
    for (int i = 0; i < NUM_CHANNELS; i++)
      gnt_vec[i] = gnt_vld && (gnt_idx == CW'(i));
  end

  always_comb begin
    rr_d = rr_q;
    if (gnt_vld) rr_d = (gnt_idx == CW'(NUM_CHANNELS - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) rr_q <= '0;
    else       rr_q <= rr_d;
  end

  assign mem_rdata = mem_q[addr_w[gnt_idx]];

  // Array contents survive reset; only the load port and granted writes change them.
  always_ff @(posedge clk) begin
    if (load_en)                        mem_q[load_addr]       <= load_data;
    else if (gnt_vld && op_wr[gnt_idx]) mem_q[addr_w[gnt_idx]] <= wdata_w[gnt_idx];
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
    memory_responder_chan #(
      .ADDR_BITS(ADDR_BITS),
      .DATA_BITS(DATA_BITS),
      .LATENCY  (LATENCY)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .rd_valid_i (mem_read_valid[g]),
      .rd_addr_i  (mem_read_address[g]),
      .wr_valid_i (mem_write_valid[g]),
      .wr_addr_i  (mem_write_address[g]),
      .wr_data_i  (mem_write_data[g]),
      .gnt_i      (gnt_vec[g]),
      .mem_rdata_i(mem_rdata),
      .req_o      (req[g]),
      .op_wr_o    (op_wr[g]),
      .addr_o     (addr_w[g]),
      .wdata_o    (wdata_w[g]),
      .rd_ready_o (mem_read_ready[g]),
      .wr_ready_o (mem_write_ready[g]),
      .rd_data_o  (mem_read_data[g])
    );
  end
endmodule

// File: tb/tb_memory_responder.sv
// Scoreboard bench for memory_responder: directed transactions push expected
// strobe cycle/data; a forked monitor matches every ready strobe against them.

module tb_memory_responder;
  localparam int AB = 8, DB = 8, NC = 4, LAT = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NC-1:0]         rd_v, wr_v, rd_rdy, wr_rdy;
  logic [NC-1:0][AB-1:0] rd_a, wr_a;
  logic [NC-1:0][DB-1:0] wr_d, rd_d;
  logic                  load_en;
  logic [AB-1:0]         load_addr;
  logic [DB-1:0]         load_data;

  logic [NC-1:0] hold_rd;
  int cyc = 0;
  int checks = 0;
  int fails = 0;

  typedef struct {
    int         ch;
    bit         wr;
    int         cyc;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];

  memory_responder #(
    .ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC), .LATENCY(LAT)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .mem_read_valid   (rd_v),
    .mem_read_address (rd_a),
    .mem_read_ready   (rd_rdy),
    .mem_read_data    (rd_d),
    .mem_write_valid  (wr_v),
    .mem_write_address(wr_a),
    .mem_write_data   (wr_d),
    .mem_write_ready  (wr_rdy),
    .load_en          (load_en),
    .load_addr        (load_addr),
    .load_data        (load_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Advance one cycle; requesters release valid on the edge after their ready.
  task automatic step();
    logic [NC-1:0] rp, wp;
    rp = rd_rdy;
    wp = wr_rdy;
    @(posedge clk);
    #1;
    for (int i = 0; i < NC; i++) begin
      if (rp[i] && !hold_rd[i]) rd_v[i] = 1'b0;
      if (wp[i]) wr_v[i] = 1'b0;
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    step();
    load_en = 1'b0;
  endtask

  task automatic rd(input int ch, input logic [7:0] a, input logic [7:0] d, input int extra);
    exp_t e;
    rd_v[ch] = 1'b1; rd_a[ch] = a;
    e.ch = ch; e.wr = 1'b0; e.cyc = cyc + 2 + LAT + extra; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic wr(input int ch, input logic [7:0] a, input logic [7:0] d, input int extra);
    exp_t e;
    wr_v[ch] = 1'b1; wr_a[ch] = a; wr_d[ch] = d;
    e.ch = ch; e.wr = 1'b1; e.cyc = cyc + 2 + LAT + extra; e.data = 8'h00;
    exp_q.push_back(e);
  endtask

  initial begin
    reset = 1'b1; rd_v = '0; wr_v = '0; rd_a = '0; wr_a = '0; wr_d = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0; hold_rd = '0;

    fork
      forever begin
        @(negedge clk);
        for (int i = 0; i < NC; i++) begin
          if (rd_rdy[i] || wr_rdy[i]) begin
            int idx;
            idx = -1;
            foreach (exp_q[j]) if (idx < 0 && exp_q[j].ch == i) idx = j;
            checks++;
            if (idx < 0) begin
              fails++;
              $display("FAIL strobe ch%0d: unexpected rd=%0d wr=%0d at cyc %0d",
                       i, rd_rdy[i], wr_rdy[i], cyc);
            end else begin
              if (wr_rdy[i] != exp_q[idx].wr || cyc != exp_q[idx].cyc ||
                  (!exp_q[idx].wr && rd_d[i] !== exp_q[idx].data) || (rd_rdy[i] && wr_rdy[i])) begin
                fails++;
                $display("FAIL strobe ch%0d: got wr=%0d cyc=%0d data=%0h expected wr=%0d cyc=%0d data=%0h",
                         i, wr_rdy[i], cyc, rd_d[i], exp_q[idx].wr, exp_q[idx].cyc, exp_q[idx].data);
              end
              exp_q.delete(idx);
            end
          end
        end
      end
    join_none

    steps(3);
    reset = 1'b0;
    check("reset rd_ready", 32'(rd_rdy), 32'h0);
    check("reset wr_ready", 32'(wr_rdy), 32'h0);
    for (int i = 0; i < NC; i++) check($sformatf("reset rd_data%0d", i), 32'(rd_d[i]), 32'h0);

    load(8'h10, 8'hAB);
    for (int k = 0; k < NC; k++) load(8'(8'h40 + k), 8'(8'hC0 + k));
    load(8'h30, 8'h3C);
    load(8'h50, 8'h11);

    // Four-way contention twice: rr pointer must wrap back to channel 0.
    for (int rep = 0; rep < 2; rep++) begin
      for (int k = 0; k < NC; k++) rd(k, 8'(8'h40 + k), 8'(8'hC0 + k), k);
      steps(10);
    end

    rd(0, 8'h10, 8'hAB, 0);
    steps(7);
    check("rd_data0 hold", 32'(rd_d[0]), 32'hAB);

    wr(1, 8'h20, 8'h5C, 0);
    steps(6);
    rd(1, 8'h20, 8'h5C, 0);
    steps(6);

    // Load lands in the cycle channel 2 would be granted: grant slips by one.
    rd(2, 8'h30, 8'h3C, 1);
    step();
    load(8'h77, 8'h99);
    steps(6);
    rd(2, 8'h77, 8'h99, 0);
    steps(6);

    hold_rd[0] = 1'b1;
    rd(0, 8'h41, 8'hC1, 0);
    steps(14);
    rd_v[0] = 1'b0;
    hold_rd[0] = 1'b0;
    steps(3);

    // Reset while a channel 3 write is still pending: no strobe, no array update.
    wr_v[3] = 1'b1; wr_a[3] = 8'h50; wr_d[3] = 8'hEE;
    step();
    reset = 1'b1; wr_v[3] = 1'b0;
    step();
    check("midrst rd_ready", 32'(rd_rdy), 32'h0);
    check("midrst wr_ready", 32'(wr_rdy), 32'h0);
    for (int i = 0; i < NC; i++) check($sformatf("midrst rd_data%0d", i), 32'(rd_d[i]), 32'h0);
    reset = 1'b0;
    steps(2);
    rd(3, 8'h50, 8'h11, 0);
    steps(8);

    foreach (exp_q[j]) begin
      checks++;
      fails++;
      $display("FAIL missing strobe ch%0d: got none expected wr=%0d at cyc %0d",
               exp_q[j].ch, exp_q[j].wr, exp_q[j].cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
